// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between two
// requesters (r0 = execute stage, r1 = address/aux unit).
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   rN_valid/rN_ready             request handshake (ready is combinational, IDLE only)
//   rN_a, rN_b, rN_op             request operands and ALU function code
//   rN_rsp_valid/rN_rsp_ready     response handshake back to requester N
//   rN_result, rN_zero            captured ALU result and zero flag for N
//   alu_a, alu_b, alu_control     registered ALU inputs (change only on accept)
//   alu_result, alu_zero          ALU combinational outputs
//   busy                          high whenever a transaction is in flight
module alu_share_arbiter #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned OP_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [DATA_W-1:0] r0_a,
    input  logic [DATA_W-1:0] r0_b,
    input  logic [OP_W-1:0]   r0_op,
    output logic              r0_rsp_valid,
    input  logic              r0_rsp_ready,
    output logic [DATA_W-1:0] r0_result,
    output logic              r0_zero,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [DATA_W-1:0] r1_a,
    input  logic [DATA_W-1:0] r1_b,
    input  logic [OP_W-1:0]   r1_op,
    output logic              r1_rsp_valid,
    input  logic              r1_rsp_ready,
    output logic [DATA_W-1:0] r1_result,
    output logic              r1_zero,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_control,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q;
    logic              rr_ptr_q;
    logic              owner_q;
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [OP_W-1:0]   alu_ctl_q;
    logic [DATA_W-1:0] res0_q;
    logic [DATA_W-1:0] res1_q;
    logic              zero0_q;
    logic              zero1_q;
    logic              rsp0_q;
    logic              rsp1_q;
    logic              busy_q;
    logic              own_rsp_ready_c;

    // Grant: a lone requester wins; on contention rr_ptr picks. Gated by reset
    // so nothing looks accepted while the block is held in reset.
    assign r0_ready = rst_n && (state_q == IDLE) && r0_valid && (!r1_valid || !rr_ptr_q);
    assign r1_ready = rst_n && (state_q == IDLE) && r1_valid && (!r0_valid ||  rr_ptr_q);

    // Only the current owner's rsp_ready can close a transaction.
    assign own_rsp_ready_c = owner_q ? r1_rsp_ready : r0_rsp_ready;

    // Arbitration / execute / response sequencer with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_ptr_q  <= 1'b0;
            owner_q   <= 1'b0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_ctl_q <= '0;
            res0_q    <= '0;
            res1_q    <= '0;
            zero0_q   <= 1'b0;
            zero1_q   <= 1'b0;
            rsp0_q    <= 1'b0;
            rsp1_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (r0_ready) begin
                        alu_a_q   <= r0_a;
                        alu_b_q   <= r0_b;
                        alu_ctl_q <= r0_op;
                        owner_q   <= 1'b0;
                        rr_ptr_q  <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= EXEC;
                    end else if (r1_ready) begin
                        alu_a_q   <= r1_a;
                        alu_b_q   <= r1_b;
                        alu_ctl_q <= r1_op;
                        owner_q   <= 1'b1;
                        rr_ptr_q  <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= EXEC;
                    end
                end
                EXEC: begin
                    // ALU inputs have been stable for a full cycle; capture.
                    if (owner_q) begin
                        res1_q  <= alu_result;
                        zero1_q <= alu_zero;
                        rsp1_q  <= 1'b1;
                    end else begin
                        res0_q  <= alu_result;
                        zero0_q <= alu_zero;
                        rsp0_q  <= 1'b1;
                    end
                    state_q <= RESP;
                end
                RESP: begin
                    if (own_rsp_ready_c) begin
                        rsp0_q  <= 1'b0;
                        rsp1_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    rsp0_q  <= 1'b0;
                    rsp1_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_control  = alu_ctl_q;
    assign r0_result    = res0_q;
    assign r1_result    = res1_q;
    assign r0_zero      = zero0_q;
    assign r1_zero      = zero1_q;
    assign r0_rsp_valid = rsp0_q;
    assign r1_rsp_valid = rsp1_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: acts as the ALU, drives directed and random
// traffic, and compares every output each cycle against a transaction-level model.
module tb_alu_share_arbiter;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned OP_W   = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              r0_valid = 1'b0, r1_valid = 1'b0;
    logic              r0_ready, r1_ready;
    logic [DATA_W-1:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
    logic [OP_W-1:0]   r0_op = '0, r1_op = '0;
    logic              r0_rsp_valid, r1_rsp_valid;
    logic              r0_rsp_ready = 1'b1, r1_rsp_ready = 1'b1;
    logic [DATA_W-1:0] r0_result, r1_result;
    logic              r0_zero, r1_zero;
    logic [DATA_W-1:0] alu_a, alu_b, alu_result;
    logic [OP_W-1:0]   alu_control;
    logic              alu_zero;
    logic              busy;

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] alu_fn(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic [OP_W-1:0] op);
        return (op == 3'b001) ? DATA_W'(a - b) : DATA_W'(a + b);
    endfunction

    // The ALU the arbiter sits beside.
    assign alu_result = alu_fn(alu_a, alu_b, alu_control);
    assign alu_zero   = (alu_result == '0);

    alu_share_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op),
        .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
        .r0_result(r0_result), .r0_zero(r0_zero),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op),
        .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
        .r1_result(r1_result), .r1_zero(r1_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: phase 0 = free, 1 = computing, 2 = answering.
    bit                started = 1'b0;
    int                m_phase = 0;
    int                m_owner = 0;
    int                m_prio  = 0;
    logic [DATA_W-1:0] m_a = '0, m_b = '0;
    logic [OP_W-1:0]   m_op = '0;
    logic [DATA_W-1:0] m_res [2];
    logic              m_zero [2];

    function automatic bit vin(input int n);
        return (n == 0) ? r0_valid : r1_valid;
    endfunction

    function automatic bit rsp_rdy(input int n);
        return (n == 0) ? r0_rsp_ready : r1_rsp_ready;
    endfunction

    function automatic bit exp_ready(input int n);
        if (!rst_n || m_phase != 0 || !vin(n)) return 1'b0;
        if (!vin(1 - n)) return 1'b1;
        return m_prio == n;
    endfunction

    always @(posedge clk) begin
        logic [DATA_W-1:0] r;
        int g;
        started = 1'b1;
        if (!rst_n) begin
            m_phase = 0; m_owner = 0; m_prio = 0;
            m_a = '0; m_b = '0; m_op = '0;
            m_res[0] = '0; m_res[1] = '0; m_zero[0] = 1'b0; m_zero[1] = 1'b0;
        end else if (m_phase == 0) begin
            g = -1;
            if (exp_ready(0)) g = 0;
            else if (exp_ready(1)) g = 1;
            if (g >= 0) begin
                m_a     = (g == 0) ? r0_a : r1_a;
                m_b     = (g == 0) ? r0_b : r1_b;
                m_op    = (g == 0) ? r0_op : r1_op;
                m_owner = g;
                m_prio  = 1 - g;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            r = alu_fn(m_a, m_b, m_op);
            m_res[m_owner]  = r;
            m_zero[m_owner] = (r == '0);
            m_phase = 2;
        end else if (rsp_rdy(m_owner)) begin
            m_phase = 0;
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (started) begin
            check("r0_ready",     32'(r0_ready),     32'(exp_ready(0)));
            check("r1_ready",     32'(r1_ready),     32'(exp_ready(1)));
            check("r0_rsp_valid", 32'(r0_rsp_valid), 32'(m_phase == 2 && m_owner == 0));
            check("r1_rsp_valid", 32'(r1_rsp_valid), 32'(m_phase == 2 && m_owner == 1));
            check("r0_result",    32'(r0_result),    32'(m_res[0]));
            check("r1_result",    32'(r1_result),    32'(m_res[1]));
            check("r0_zero",      32'(r0_zero),      32'(m_zero[0]));
            check("r1_zero",      32'(r1_zero),      32'(m_zero[1]));
            check("alu_a",        32'(alu_a),        32'(m_a));
            check("alu_b",        32'(alu_b),        32'(m_b));
            check("alu_control",  32'(alu_control),  32'(m_op));
            check("busy",         32'(busy),         32'(m_phase != 0));
        end
    end

    // Accept log taken from the DUT handshake itself.
    int cyc = 0;
    int acc_who [$];
    int acc_cyc [$];
    always @(posedge clk) begin
        cyc++;
        if (rst_n && r0_valid && r0_ready) begin acc_who.push_back(0); acc_cyc.push_back(cyc); end
        if (rst_n && r1_valid && r1_ready) begin acc_who.push_back(1); acc_cyc.push_back(cyc); end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) tick();
        rst_n = 1'b1;
    endtask

    // Waits (bounded) at negedges until requester n is granted; returns after accept edge +1.
    task automatic wait_accept(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((n == 0) ? r0_ready : r1_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        else tick();
    endtask

    task automatic do_req(input int n, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                          input logic [OP_W-1:0] op, input logic [DATA_W-1:0] exp_r,
                          input logic exp_z);
        bit ok;
        if (n == 0) begin r0_a = a; r0_b = b; r0_op = op; r0_valid = 1'b1; end
        else        begin r1_a = a; r1_b = b; r1_op = op; r1_valid = 1'b1; end
        wait_accept(n, ok);
        r0_valid = 1'b0; r1_valid = 1'b0;
        if (ok) begin
            check("lit_alu_a", 32'(alu_a), 32'(a));
            check("lit_alu_control", 32'(alu_control), 32'(op));
            check("lit_busy_exec", 32'(busy), 32'd1);
            tick();
            check("lit_rsp_valid", 32'((n == 0) ? r0_rsp_valid : r1_rsp_valid), 32'd1);
            check("lit_result", 32'((n == 0) ? r0_result : r1_result), 32'(exp_r));
            check("lit_zero", 32'((n == 0) ? r0_zero : r1_zero), 32'(exp_z));
            check("lit_model_result", 32'(m_res[n]), 32'(exp_r));
            tick();
            check("lit_rsp_dropped", 32'((n == 0) ? r0_rsp_valid : r1_rsp_valid), 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit ok;
        // Held in reset with a pending request: nothing granted, everything zero.
        rst_n = 1'b0; r0_valid = 1'b1; r0_a = 16'h0055;
        tick();
        check("lit_reset_r0_ready", 32'(r0_ready), 32'd0);
        tick();
        check("lit_reset_busy", 32'(busy), 32'd0);
        check("lit_reset_alu_a", 32'(alu_a), 32'd0);
        check("lit_reset_r0_rsp_valid", 32'(r0_rsp_valid), 32'd0);
        r0_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // Basic add, then sub to zero, sub wrap, and op=111 behaving as add.
        do_req(0, 16'h0003, 16'h0004, 3'b000, 16'h0007, 1'b0);
        do_req(1, 16'h1234, 16'h1234, 3'b001, 16'h0000, 1'b1);
        do_req(1, 16'h0000, 16'h0001, 3'b001, 16'hFFFF, 1'b0);
        do_req(1, 16'h0002, 16'h0002, 3'b111, 16'h0004, 1'b0);

        // Continuous contention: alternating grants, one every 3 cycles.
        do_reset(2);
        acc_who.delete(); acc_cyc.delete();
        r0_a = 16'd10; r0_b = 16'd5; r0_op = 3'b000;
        r1_a = 16'd10; r1_b = 16'd5; r1_op = 3'b001;
        r0_valid = 1'b1; r1_valid = 1'b1;
        repeat (12) tick();
        r0_valid = 1'b0; r1_valid = 1'b0;
        repeat (3) tick();
        check("lit_grant_count_ge4", 32'(acc_who.size() >= 4), 32'd1);
        for (int i = 0; i < 4 && i < acc_who.size(); i++)
            check("lit_grant_order", 32'(acc_who[i]), 32'(i % 2));
        for (int i = 0; i + 1 < 4 && i + 1 < acc_cyc.size(); i++)
            check("lit_grant_spacing", 32'(acc_cyc[i+1] - acc_cyc[i]), 32'd3);
        check("lit_r0_result_rr", 32'(r0_result), 32'd15);
        check("lit_r1_result_rr", 32'(r1_result), 32'd5);

        // Owner stalls the response; the other requester must wait.
        do_reset(1);
        r0_rsp_ready = 1'b0;
        r0_a = 16'd9; r0_b = 16'd9; r0_op = 3'b001; r0_valid = 1'b1;
        r1_a = 16'd1; r1_b = 16'd2; r1_op = 3'b000; r1_valid = 1'b1;
        wait_accept(0, ok);
        r0_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("lit_stall_rsp_valid", 32'(r0_rsp_valid), 32'd1);
            check("lit_stall_result", 32'(r0_result), 32'd0);
            check("lit_stall_zero", 32'(r0_zero), 32'd1);
            check("lit_stall_r1_ready", 32'(r1_ready), 32'd0);
            check("lit_stall_busy", 32'(busy), 32'd1);
            tick();
        end
        r0_rsp_ready = 1'b1;
        tick();
        check("lit_release_r1_ready", 32'(r1_ready), 32'd1);
        tick();
        r1_valid = 1'b0;
        check("lit_release_r1_granted", 32'(acc_who.size() > 0 && acc_who[$] == 1), 32'd1);
        repeat (3) tick();
        check("lit_r1_result_after_stall", 32'(r1_result), 32'd3);

        // Reset during EXEC discards the transaction and restores r0 priority.
        r1_a = 16'd7; r1_b = 16'd7; r1_op = 3'b000; r1_valid = 1'b1;
        wait_accept(1, ok);
        r1_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        check("lit_midreset_rsp_valid", 32'(r1_rsp_valid), 32'd0);
        check("lit_midreset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        r0_valid = 1'b1; r1_valid = 1'b1;
        @(negedge clk);
        check("lit_postreset_r0_ready", 32'(r0_ready), 32'd1);
        check("lit_postreset_r1_ready", 32'(r1_ready), 32'd0);
        tick();
        r0_valid = 1'b0; r1_valid = 1'b0;
        repeat (3) tick();

        // Random traffic, including operand churn, stalls and rare resets.
        for (int i = 0; i < 1500; i++) begin
            r0_valid     = ($urandom_range(0, 99) < 60);
            r1_valid     = ($urandom_range(0, 99) < 60);
            r0_a         = DATA_W'($urandom);
            r0_b         = DATA_W'($urandom);
            r1_a         = DATA_W'($urandom);
            r1_b         = DATA_W'($urandom);
            r0_op        = OP_W'($urandom_range(0, 7));
            r1_op        = OP_W'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) r1_b = r1_a;
            r0_rsp_ready = ($urandom_range(0, 99) < 70);
            r1_rsp_ready = ($urandom_range(0, 99) < 70);
            rst_n        = ($urandom_range(0, 99) != 0);
            tick();
        end
        rst_n = 1'b1; r0_valid = 1'b0; r1_valid = 1'b0;
        r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
